// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median filter sequencer.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned SORT_LAT = 3;

    typedef struct packed {
        logic sof;
        logic eol;
        logic border;
    } flag_t;

    localparam int unsigned FLAG_W = $bits(flag_t);

endpackage

// File: rtl/median_vld_pipe.sv
// Fixed-latency shift register carrying valid and flag bits alongside the sort network.
module median_vld_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/median_win_ctrl.sv
// 3x3 median window sequencer: pixel position counting, line-buffer/window control,
// and flag alignment with the sort network output, including end-of-frame flush.
module median_win_ctrl #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned SORT_LAT = median_pkg::SORT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic              lb_wr_en,
    output logic [ADDR_W-1:0] lb_addr,
    output logic              shift_en,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eol,
    output logic              border_sel,
    output logic              busy,
    output logic              frame_err
);
    import median_pkg::*;

    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned FL_W   = $clog2(IMG_W + 1);
    localparam int unsigned PIPE_W = 1 + FLAG_W;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] cc;
    logic [ROW_W-1:0]  cr;
    logic [FL_W-1:0]   fl_cnt;
    logic              take_sof;
    logic              take_px;
    logic              last_px;
    logic              fl_done;
    logic              win_vld;
    flag_t             win_flags;
    flag_t             out_flags;
    logic [PIPE_W-1:0] stage_q;
    logic [PIPE_W-1:0] pipe_q;
    logic              err_q;

    assign last_px = take_px && !take_sof && (state == RUN) &&
                     (row == ROW_W'(IMG_H - 1)) && (col == ADDR_W'(IMG_W - 1));
    assign fl_done = (fl_cnt == FL_W'(IMG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take_sof) state_nxt = RUN;
            RUN:     if (last_px)  state_nxt = FLUSH;
            FLUSH:   if (fl_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and per-cycle datapath strobes; only RUN counts non-sof pixels.
    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        take_sof = 1'b0;
        take_px  = 1'b0;
        unique case (state)
            IDLE: begin
                take_sof = in_valid & in_sof;
                take_px  = in_valid & in_sof;
            end
            RUN: begin
                busy     = 1'b1;
                take_sof = in_valid & in_sof;
                take_px  = in_valid;
            end
            FLUSH: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
            default: ;
        endcase
        lb_wr_en = take_px;
        lb_addr  = take_sof ? '0 : col;
        shift_en = take_px | (state == FLUSH);
    end

    // Next input position; sof pixel is (0,0) so the counter resumes at column 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            fl_cnt <= '0;
        end else begin
            if (take_sof) begin
                col <= ADDR_W'(1);
                row <= '0;
            end else if (take_px) begin
                if (col == ADDR_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + ADDR_W'(1);
                end
            end
            if (state == FLUSH) fl_cnt <= fl_done ? '0 : fl_cnt + FL_W'(1);
        end
    end

    // A full window exists once the linear index reaches IMG_W+1; flush cycles always complete one.
    assign win_vld = (state == FLUSH) ||
                     (take_px && !take_sof &&
                      ((row >= ROW_W'(2)) || ((row == ROW_W'(1)) && (col != '0))));

    // Centre position tracked incrementally alongside the window stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= '0;
            cr <= '0;
        end else if (take_sof) begin
            cc <= '0;
            cr <= '0;
        end else if (win_vld) begin
            if (cc == ADDR_W'(IMG_W - 1)) begin
                cc <= '0;
                cr <= (cr == ROW_W'(IMG_H - 1)) ? '0 : cr + ROW_W'(1);
            end else begin
                cc <= cc + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        win_flags.sof    = (cr == '0) && (cc == '0);
        win_flags.eol    = (cc == ADDR_W'(IMG_W - 1));
        win_flags.border = (cr == '0) || (cr == ROW_W'(IMG_H - 1)) ||
                           (cc == '0) || (cc == ADDR_W'(IMG_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stage_q <= win_vld ? {1'b1, win_flags} : '0;
            err_q   <= (state == RUN) && take_sof;
        end
    end

    median_vld_pipe #(
        .DEPTH (SORT_LAT),
        .WIDTH (PIPE_W)
    ) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (stage_q),
        .dout  (pipe_q)
    );

    assign out_flags  = flag_t'(pipe_q[FLAG_W-1:0]);
    assign out_valid  = pipe_q[PIPE_W-1];
    assign out_sof    = out_flags.sof;
    assign out_eol    = out_flags.eol;
    assign border_sel = out_flags.border;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_median_win_ctrl.sv
// Randomized scoreboard bench for median_win_ctrl on a 4x3 image.
module tb_median_win_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int AW = 2;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic          lb_wr_en;
    logic [AW-1:0] lb_addr;
    logic          shift_en;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic          border_sel;
    logic          busy;
    logic          frame_err;

    median_win_ctrl #(
        .IMG_W    (W),
        .IMG_H    (H),
        .ADDR_W   (AW),
        .SORT_LAT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .lb_wr_en   (lb_wr_en),
        .lb_addr    (lb_addr),
        .shift_en   (shift_en),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .border_sel (border_sel),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit [2:0] flg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_out = 0;
    int   cyc = 0;

    // Reference frame state: pixels counted, flush steps left, error pulse owed.
    int   m_k = 0;
    bit   m_run = 1'b0;
    int   m_fl = 0;
    bit   err_pend = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit [2:0] centre_flags(input int j);
        int r;
        int c;
        r = j / W;
        c = j % W;
        return {(r == 0) && (c == 0), c == W - 1,
                (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1)};
    endfunction

    function automatic void push_centre(input int j);
        exp_t e;
        e.cyc = cyc + LAT;
        e.flg = centre_flags(j);
        sb.push_back(e);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-side model: predicts handshake strobes and queues expected outputs.
    always @(negedge clk) begin
        bit e_ready;
        bit e_busy;
        bit e_shift;
        bit e_wr;
        bit new_err;
        if (!rst_n) begin
            sb.delete();
            m_k = 0;
            m_run = 1'b0;
            m_fl = 0;
            err_pend = 1'b0;
            chk("reset_outputs",
                int'({in_ready, lb_wr_en, shift_en, out_valid, out_sof, out_eol,
                      border_sel, busy, frame_err}),
                int'(9'b1_0000_0000));
        end else begin
            e_ready = (m_fl == 0);
            e_busy  = m_run || (m_fl > 0);
            e_shift = 1'b0;
            e_wr    = 1'b0;
            new_err = 1'b0;
            if (m_fl > 0) begin
                e_shift = 1'b1;
                push_centre(W * H - W - 1 + (W + 1 - m_fl));
                m_fl--;
            end else if (in_valid && (m_run || in_sof)) begin
                if (in_sof) begin
                    new_err = m_run;
                    m_k = 0;
                end
                e_shift = 1'b1;
                e_wr = 1'b1;
                chk("lb_addr", int'(lb_addr), m_k % W);
                if (m_k >= W + 1) push_centre(m_k - W - 1);
                if (m_k == W * H - 1) begin
                    m_run = 1'b0;
                    m_fl = W + 1;
                end else begin
                    m_run = 1'b1;
                    m_k++;
                end
            end
            chk("in_ready", int'(in_ready), int'(e_ready));
            chk("busy", int'(busy), int'(e_busy));
            chk("shift_en", int'(shift_en), int'(e_shift));
            chk("lb_wr_en", int'(lb_wr_en), int'(e_wr));
            chk("frame_err", int'(frame_err), int'(err_pend));
            err_pend = new_err;
        end
    end

    // Output monitor: pops the scoreboard whenever an output is due.
    always @(negedge clk) begin
        bit   due;
        exp_t e;
        if (rst_n) begin
            due = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("out_valid", int'(out_valid), int'(due));
            if (due) begin
                e = sb.pop_front();
                chk("out_flags", int'({out_sof, out_eol, border_sel}), int'(e.flg));
            end
            if (out_valid) n_out++;
        end
    end

    task automatic send_px(input bit sof, input int gap_pct);
        int guard;
        for (int b = 0; b < 6 && int'($urandom_range(99)) < gap_pct; b++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_sof = sof;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input int n_px, input int gap_pct);
        for (int p = 0; p < n_px; p++) send_px(p == 0, gap_pct);
    endtask

    task automatic drain();
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Stray pixels without sof while idle are ignored.
        for (int i = 0; i < 3; i++) send_px(1'b0, 0);

        base = n_out;
        send_frame(W * H, 0);
        drain();
        chk("count_continuous", n_out - base, W * H);

        base = n_out;
        send_frame(W * H, 50);
        drain();
        chk("count_gaps", n_out - base, W * H);

        base = n_out;
        send_frame(7, 0);
        send_frame(W * H, 30);
        drain();
        chk("count_resync", n_out - base, 2 + W * H);

        base = n_out;
        send_frame(9, 0);
        chk("pipe_full", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_clear", int'({out_valid, out_sof, out_eol, border_sel, busy, frame_err}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_px(1'b0, 0);
        drain();
        chk("count_after_reset", n_out - base, 0);

        base = n_out;
        send_frame(W * H, 0);
        send_frame(W * H, 0);
        drain();
        chk("count_back_to_back", n_out - base, 2 * W * H);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
